// File: rtl/antiq_cmd_arbiter_if.sv
// Requester-fabric and queue-side signal bundle for antiq_cmd_arbiter.
// slave = arbiter view, master = requesters plus queue instance view.
interface antiq_cmd_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 5,
    parameter int DW    = 16
);
    localparam int ID_W = $clog2(DEPTH) + 1;

    logic [N_REQ-1:0]      req_valid_i;
    logic [2*N_REQ-1:0]    req_op_i;
    logic [DW*N_REQ-1:0]   req_data_i;
    logic [ID_W*N_REQ-1:0] req_id_i;
    logic [N_REQ-1:0]      req_gnt_o;
    logic [N_REQ-1:0]      rsp_valid_o;
    logic [DW-1:0]         rsp_data_o;
    logic [ID_W-1:0]       rsp_id_o;
    logic                  rsp_err_o;

    logic                  q_push_o;
    logic                  q_pop_o;
    logic                  q_drop_o;
    logic [DW-1:0]         q_data_o;
    logic [ID_W-1:0]       q_drop_id_o;
    logic                  q_push_rdy_i;
    logic                  q_pop_rdy_i;
    logic                  q_drop_rdy_i;
    logic                  q_full_i;
    logic                  q_empty_i;
    logic [ID_W-1:0]       q_push_id_i;
    logic [DW-1:0]         q_data_i;

    modport slave (
        input  req_valid_i, req_op_i, req_data_i, req_id_i,
        input  q_push_rdy_i, q_pop_rdy_i, q_drop_rdy_i, q_full_i, q_empty_i,
        input  q_push_id_i, q_data_i,
        output req_gnt_o, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o,
        output q_push_o, q_pop_o, q_drop_o, q_data_o, q_drop_id_o
    );

    modport master (
        output req_valid_i, req_op_i, req_data_i, req_id_i,
        output q_push_rdy_i, q_pop_rdy_i, q_drop_rdy_i, q_full_i, q_empty_i,
        output q_push_id_i, q_data_i,
        input  req_gnt_o, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o,
        input  q_push_o, q_pop_o, q_drop_o, q_data_o, q_drop_id_o
    );
endinterface

// File: rtl/antiq_cmd_arbiter.sv
// Round-robin arbiter sharing one AnTiQ queue command port among N_REQ requesters.
// Define ANTIQ_ARB_POP_PRIO_EN to let pops win over push/drop in IDLE.
//
// state | meaning
// IDLE  | pick a requester, latch its command, reject or go issue
// ISSUE | strobe the queue command, sample head data for a pop
// WAIT  | wait for the op's ready (from 2nd cycle) or time out
// RESP  | return data/ID/error to the winner
module antiq_cmd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DEPTH   = 5,
    parameter int DW      = 16,
    parameter int TIMEOUT = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    antiq_cmd_arbiter_if.slave  arb_if
);
    localparam int ID_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_PID  = CNT_W'(TIMEOUT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_DROP = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] win_q;
    logic [1:0]       op_q;
    logic [DW-1:0]    data_q;
    logic [ID_W-1:0]  id_q;
    logic [DW-1:0]    pop_data_q;
    logic [ID_W-1:0]  push_id_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [DW-1:0]    rsp_data_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic             rsp_err_q;
    logic             q_push_q;
    logic             q_pop_q;
    logic             q_drop_q;
    logic [DW-1:0]    q_data_q;
    logic [ID_W-1:0]  q_drop_id_q;

    // Lowest offset from start wins; result is {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                               input logic [IDX_W-1:0] start);
        logic [IDX_W:0] res;
        logic [IDX_W:0] sum;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, start} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            if (mask[sum[IDX_W-1:0]]) begin
                res = {1'b1, sum[IDX_W-1:0]};
            end
        end
        return res;
    endfunction

    logic [IDX_W:0]   sel_d;
    logic             sel_vld;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] sel_nxt;
    logic [1:0]       sel_op;
    logic [DW-1:0]    sel_data;
    logic [ID_W-1:0]  sel_id;
    logic             sel_rej;
    logic             sel_rdy;
    logic             op_rdy;

`ifdef ANTIQ_ARB_POP_PRIO_EN
    logic [IDX_W-1:0] pop_ptr_q;
    logic [N_REQ-1:0] pop_mask;
    logic [IDX_W:0]   pick_all;
    logic [IDX_W:0]   pick_pop;

    always_comb begin
        pop_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pop_mask[i] = arb_if.req_valid_i[i] && (arb_if.req_op_i[2*i +: 2] == OP_POP);
        end
    end

    assign pick_all = rr_pick(arb_if.req_valid_i, ptr_q);
    assign pick_pop = rr_pick(pop_mask, pop_ptr_q);
    assign sel_d    = pick_pop[IDX_W] ? pick_pop : pick_all;
`else
    assign sel_d    = rr_pick(arb_if.req_valid_i, ptr_q);
`endif

    assign sel_vld  = sel_d[IDX_W];
    assign sel_idx  = sel_d[IDX_W-1:0];
    assign sel_nxt  = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
    assign sel_op   = arb_if.req_op_i[2*int'(sel_idx) +: 2];
    assign sel_data = arb_if.req_data_i[DW*int'(sel_idx) +: DW];
    assign sel_id   = arb_if.req_id_i[ID_W*int'(sel_idx) +: ID_W];

    assign sel_rej = (sel_op == OP_RSV)
                   || ((sel_op == OP_PUSH) && arb_if.q_full_i)
                   || (((sel_op == OP_POP) || (sel_op == OP_DROP)) && arb_if.q_empty_i);

    always_comb begin
        sel_rdy = 1'b0;
        case (sel_op)
            OP_PUSH: sel_rdy = arb_if.q_push_rdy_i;
            OP_DROP: sel_rdy = arb_if.q_drop_rdy_i;
            OP_POP:  sel_rdy = arb_if.q_pop_rdy_i;
            default: sel_rdy = 1'b0;
        endcase
    end

    always_comb begin
        op_rdy = 1'b0;
        case (op_q)
            OP_PUSH: op_rdy = arb_if.q_push_rdy_i;
            OP_DROP: op_rdy = arb_if.q_drop_rdy_i;
            OP_POP:  op_rdy = arb_if.q_pop_rdy_i;
            default: op_rdy = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
`ifdef ANTIQ_ARB_POP_PRIO_EN
            pop_ptr_q   <= '0;
`endif
            win_q       <= '0;
            op_q        <= OP_PUSH;
            data_q      <= '0;
            id_q        <= '0;
            pop_data_q  <= '0;
            push_id_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            q_push_q    <= 1'b0;
            q_pop_q     <= 1'b0;
            q_drop_q    <= 1'b0;
            q_data_q    <= '0;
            q_drop_id_q <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            q_push_q    <= 1'b0;
            q_pop_q     <= 1'b0;
            q_drop_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    // A ready-blocked winner holds off all others; no grant this cycle.
                    if (sel_vld && (sel_rej || sel_rdy)) begin
                        gnt_q       <= N_REQ'(1) << sel_idx;
                        win_q       <= sel_idx;
                        op_q        <= sel_op;
                        data_q      <= sel_data;
                        id_q        <= sel_id;
                        q_data_q    <= sel_data;
                        q_drop_id_q <= sel_id;
                        pop_data_q  <= '0;
                        push_id_q   <= '0;
                        err_q       <= sel_rej;
`ifdef ANTIQ_ARB_POP_PRIO_EN
                        if (sel_op == OP_POP) begin
                            pop_ptr_q <= sel_nxt;
                        end else begin
                            ptr_q <= sel_nxt;
                        end
`else
                        ptr_q       <= sel_nxt;
`endif
                        state_q     <= sel_rej ? RESP : ISSUE;
                    end
                end

                ISSUE: begin
                    q_push_q <= (op_q == OP_PUSH);
                    q_pop_q  <= (op_q == OP_POP);
                    q_drop_q <= (op_q == OP_DROP);
                    if (op_q == OP_POP) begin
                        pop_data_q <= arb_if.q_data_i;
                    end
                    cnt_q    <= CNT_LOAD;
                    state_q  <= WAIT;
                end

                WAIT: begin
                    // The queue answers a push with its ID one cycle after the strobe.
                    if ((op_q == OP_PUSH) && (cnt_q == CNT_PID)) begin
                        push_id_q <= arb_if.q_push_id_i;
                    end
                    if ((cnt_q != CNT_LOAD) && op_rdy) begin
                        err_q   <= 1'b0;
                        state_q <= RESP;
                    end else if (cnt_q == '0) begin
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end

                RESP: begin
                    rsp_valid_q <= N_REQ'(1) << win_q;
                    rsp_err_q   <= err_q;
                    if (!err_q) begin
                        rsp_data_q <= (op_q == OP_POP)  ? pop_data_q : '0;
                        rsp_id_q   <= (op_q == OP_PUSH) ? push_id_q  : '0;
                    end
                    state_q     <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb_if.req_gnt_o   = gnt_q;
    assign arb_if.rsp_valid_o = rsp_valid_q;
    assign arb_if.rsp_data_o  = rsp_data_q;
    assign arb_if.rsp_id_o    = rsp_id_q;
    assign arb_if.rsp_err_o   = rsp_err_q;
    assign arb_if.q_push_o    = q_push_q;
    assign arb_if.q_pop_o     = q_pop_q;
    assign arb_if.q_drop_o    = q_drop_q;
    assign arb_if.q_data_o    = q_data_q;
    assign arb_if.q_drop_id_o = q_drop_id_q;

endmodule

// File: tb/tb_antiq_cmd_arbiter.sv
// Scoreboard bench for antiq_cmd_arbiter: the bench plays requesters and queue,
// predicts winners and responses from a pending-request model.
`timescale 1ns/1ps
module tb_antiq_cmd_arbiter;
    localparam int N_REQ   = 4;
    localparam int DEPTH   = 5;
    localparam int DW      = 16;
    localparam int TIMEOUT = 16;
    localparam int ID_W    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    antiq_cmd_arbiter_if #(.N_REQ(N_REQ), .DEPTH(DEPTH), .DW(DW)) bus ();

    antiq_cmd_arbiter #(
        .N_REQ(N_REQ), .DEPTH(DEPTH), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .arb_if (bus)
    );

    typedef struct {
        int              idx;
        bit              err;
        logic [DW-1:0]   data;
        logic [ID_W-1:0] id;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit              pend   [N_REQ];
    logic [1:0]      p_op   [N_REQ];
    logic [DW-1:0]   p_data [N_REQ];
    logic [ID_W-1:0] p_id   [N_REQ];
    int              m_ptr     = 0;
    int              m_pop_ptr = 0;
    int              id_ctr    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"}, 64'(bus.req_gnt_o), 64'd0);
        check({tag, "_rsp"}, {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o, bus.rsp_id_o}, 64'd0);
        check({tag, "_strobes"}, {bus.q_push_o, bus.q_pop_o, bus.q_drop_o}, 64'd0);
        check({tag, "_qbus"}, {bus.q_data_o, bus.q_drop_id_o}, 64'd0);
    endtask

    task automatic set_rdy(input logic [1:0] op, input bit v);
        case (op)
            2'b00:   bus.q_push_rdy_i = v;
            2'b01:   bus.q_drop_rdy_i = v;
            2'b10:   bus.q_pop_rdy_i  = v;
            default: ;
        endcase
    endtask

    task automatic add_req(input int i, input logic [1:0] op, input logic [DW-1:0] d,
                           input logic [ID_W-1:0] id);
        pend[i]   = 1'b1;
        p_op[i]   = op;
        p_data[i] = d;
        p_id[i]   = id;
    endtask

    // Winner: first pending requester at or after the pointer, wrapping.
    function automatic int model_pick();
        int w = -1;
        int j;
`ifdef ANTIQ_ARB_POP_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            j = (m_pop_ptr + i) % N_REQ;
            if (w < 0 && pend[j] && p_op[j] == 2'b10) w = j;
        end
        if (w >= 0) return w;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            j = (m_ptr + i) % N_REQ;
            if (w < 0 && pend[j]) w = j;
        end
        return w;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid_o != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(bus.rsp_valid_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", 64'(bus.rsp_valid_o), 64'(1) << e.idx);
                    check("rsp_err",   64'(bus.rsp_err_o),   64'(e.err));
                    check("rsp_data",  64'(bus.rsp_data_o),  64'(e.data));
                    check("rsp_id",    64'(bus.rsp_id_o),    64'(e.id));
                    check("rsp_cycle", 64'(cyc),             64'(e.cyc));
                end
            end
        end
    end

    // low_cycles: WAIT cycles with the op's ready held low; rst_at: WAIT cycle to reset in (0 = none)
    task automatic do_round(input bit full, input bit empty, input int low_cycles, input int rst_at);
        int              w;
        int              g;
        int              k;
        bit              rej;
        bit              tout;
        bit              got;
        logic [1:0]      op;
        logic [DW-1:0]   head;
        logic [DW-1:0]   wdata;
        logic [ID_W-1:0] wid;
        logic [ID_W-1:0] pid;
        logic [2:0]      strb;
        exp_t            e;

        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_valid_i[i]              = pend[i];
            bus.req_op_i[2*i +: 2]          = p_op[i];
            bus.req_data_i[DW*i +: DW]      = p_data[i];
            bus.req_id_i[ID_W*i +: ID_W]    = p_id[i];
        end
        bus.q_full_i     = full;
        bus.q_empty_i    = empty;
        bus.q_push_rdy_i = 1'b1;
        bus.q_pop_rdy_i  = 1'b1;
        bus.q_drop_rdy_i = 1'b1;
        head             = DW'($urandom);
        bus.q_data_i     = head;
        bus.q_push_id_i  = ID_W'($urandom);

        w = model_pick();
        if (w < 0) return;
        op    = p_op[w];
        wdata = p_data[w];
        wid   = p_id[w];
        rej   = (op == 2'b11) || (op == 2'b00 && full) || ((op == 2'b01 || op == 2'b10) && empty);

        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (bus.req_gnt_o != '0) got = 1'b1;
        end
        bus.req_valid_i = '0;
        pend[w] = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: no grant for req%0d within 40 cycles", w);
            return;
        end
        check("grant", 64'(bus.req_gnt_o), 64'(1) << w);
        g = cyc;
`ifdef ANTIQ_ARB_POP_PRIO_EN
        if (op == 2'b10) m_pop_ptr = (w + 1) % N_REQ;
        else             m_ptr     = (w + 1) % N_REQ;
`else
        m_ptr = (w + 1) % N_REQ;
`endif

        if (rej) begin
            e = '{idx: w, err: 1'b1, data: '0, id: '0, cyc: g + 1};
            exp_q.push_back(e);
            @(negedge clk);
            check("rej_no_strobe", {bus.q_push_o, bus.q_pop_o, bus.q_drop_o}, 64'd0);
            return;
        end

        tout = (low_cycles + 1 > TIMEOUT);
        k    = tout ? TIMEOUT : ((low_cycles + 1 < 2) ? 2 : low_cycles + 1);
        pid  = ID_W'((id_ctr % DEPTH) + 1);
        if (op == 2'b00) id_ctr++;
        e.idx  = w;
        e.err  = tout;
        e.data = (!tout && op == 2'b10) ? head : '0;
        e.id   = (!tout && op == 2'b00) ? pid  : '0;
        e.cyc  = g + k + 2;
        exp_q.push_back(e);
        set_rdy(op, 1'b0);
        strb = (op == 2'b00) ? 3'b100 : (op == 2'b10) ? 3'b010 : 3'b001;

        for (int j = 1; j <= low_cycles + 1 || j <= 3; j++) begin
            @(negedge clk);
            if (j == rst_at) begin
                rst = 1'b1;
                #1;
                check_quiet("reset_in_wait");
                void'(exp_q.pop_back());
                repeat (2) @(negedge clk);
                rst       = 1'b0;
                m_ptr     = 0;
                m_pop_ptr = 0;
                return;
            end
            if (j == 1) begin
                check("issue_strobe", {bus.q_push_o, bus.q_pop_o, bus.q_drop_o}, 64'(strb));
                check("issue_q_data", 64'(bus.q_data_o), 64'(wdata));
                check("issue_drop_id", 64'(bus.q_drop_id_o), 64'(wid));
                bus.q_data_i    = DW'($urandom);
                bus.q_push_id_i = pid;
            end
            if (j == 3) bus.q_push_id_i = ~pid;
            bus.q_push_rdy_i = 1'($urandom);
            bus.q_pop_rdy_i  = 1'($urandom);
            bus.q_drop_rdy_i = 1'($urandom);
            set_rdy(op, (j >= low_cycles + 1) ? 1'b1 : 1'b0);
        end
        while (cyc < e.cyc) @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        bus.req_valid_i  = '0;
        bus.req_op_i     = '0;
        bus.req_data_i   = '0;
        bus.req_id_i     = '0;
        bus.q_push_rdy_i = 1'b1;
        bus.q_pop_rdy_i  = 1'b1;
        bus.q_drop_rdy_i = 1'b1;
        bus.q_full_i     = 1'b0;
        bus.q_empty_i    = 1'b0;
        bus.q_push_id_i  = '0;
        bus.q_data_i     = '0;
        for (int i = 0; i < N_REQ; i++) add_req(i, 2'b00, '0, '0);
        for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;

        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        add_req(0, 2'b00, 16'h0010, '0);
        do_round(1'b0, 1'b0, 1, 0);

        add_req(2, 2'b10, DW'($urandom), '0);
        do_round(1'b0, 1'b1, 0, 0);

        add_req(1, 2'b01, DW'($urandom), ID_W'(3));
        do_round(1'b0, 1'b0, 20, 0);

        add_req(3, 2'b00, DW'($urandom), '0);
        do_round(1'b0, 1'b0, 5, 3);

        for (int i = 0; i < N_REQ; i++) add_req(i, 2'b00, DW'($urandom), '0);
        repeat (N_REQ) do_round(1'b0, 1'b0, $urandom_range(0, 3), 0);

        add_req(0, 2'b00, DW'($urandom), '0);
        add_req(3, 2'b10, DW'($urandom), '0);
        repeat (2) do_round(1'b0, 1'b0, 1, 0);

        for (int r = 0; r < 150; r++) begin
            n = 0;
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 7))
                        0, 1, 2: add_req(i, 2'b00, DW'($urandom), ID_W'($urandom));
                        3, 4:    add_req(i, 2'b01, DW'($urandom), ID_W'($urandom));
                        5, 6:    add_req(i, 2'b10, DW'($urandom), ID_W'($urandom));
                        default: add_req(i, 2'b11, DW'($urandom), ID_W'($urandom));
                    endcase
                end
                if (pend[i]) n++;
            end
            if (n == 0) add_req($urandom_range(0, N_REQ - 1), 2'b00, DW'($urandom), '0);
            do_round($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                     ($urandom_range(0, 5) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 5), 0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
